// File: rtl/fizzbuzz_tx_fmt_if.sv
// fizzbuzz_tx_fmt_if: request/transmit bundle between the BCD controller,
// the FizzBuzz formatter and the UART transmitter.
// Signals: i_go/i_bcd (request), i_tx_busy (tx status), o_tx_data/o_tx_valid
// (byte strobe), o_busy/o_overrun (formatter status).
interface fizzbuzz_tx_fmt_if #(
  parameter int CNT_DIGITS = 2
);
  logic                    i_go;
  logic [4*CNT_DIGITS-1:0] i_bcd;
  logic                    i_tx_busy;
  logic [7:0]              o_tx_data;
  logic                    o_tx_valid;
  logic                    o_busy;
  logic                    o_overrun;

  // Formatter side
  modport slave (
    input  i_go, i_bcd, i_tx_busy,
    output o_tx_data, o_tx_valid, o_busy, o_overrun
  );

  // Controller / transmitter side
  modport master (
    output i_go, i_bcd, i_tx_busy,
    input  o_tx_data, o_tx_valid, o_busy, o_overrun
  );
endinterface

// File: rtl/fizzbuzz_tx_fmt.sv
// fizzbuzz_tx_fmt: classifies one BCD count per i_go as Fizz/Buzz/FizzBuzz/number
// and streams the ASCII text one byte at a time to a valid/busy UART transmitter.
// Latency: i_go to first o_tx_valid is 2 cycles; one byte outstanding at a time.
// Ports: clk, rst (sync active-low), bus (fizzbuzz_tx_fmt_if.slave: i_go, i_bcd,
// i_tx_busy, o_tx_data, o_tx_valid, o_busy, o_overrun).
// Build option: define FIZZBUZZ_CRLF_EN to append CR LF after every message.
module fizzbuzz_tx_fmt #(
  parameter int CNT_DIGITS = 2,
  parameter int HOLD_MAX   = 2
) (
  input  logic              clk,
  input  logic              rst,
  fizzbuzz_tx_fmt_if.slave  bus
);

  localparam int BASE_DEPTH = (CNT_DIGITS > 8) ? CNT_DIGITS : 8;
`ifdef FIZZBUZZ_CRLF_EN
  localparam int TERM_LEN = 2;
`else
  localparam int TERM_LEN = 0;
`endif
  localparam int DEPTH = BASE_DEPTH + TERM_LEN;
  localparam int LEN_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);
  // Sized for non-BCD digits too so the sum never wraps.
  localparam int SUM_W = $clog2(15 * CNT_DIGITS + 1);
  localparam int HC_W  = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  // "Fizz" is the first four characters, "Buzz" the last four.
  localparam logic [63:0] TXT_FIZZBUZZ = "FizzBuzz";

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLASSIFY,
    S_EMIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [4*CNT_DIGITS-1:0] r_bcd;
  logic [7:0]              r_buf [DEPTH];
  logic [LEN_W-1:0]        r_len;
  logic [LEN_W-1:0]        r_idx;
  logic [HC_W-1:0]         r_hold_cnt;

  logic [7:0]              w_buf [DEPTH];
  logic [LEN_W-1:0]        w_len;
  logic [LEN_W-1:0]        w_mlen;
  logic [SUM_W-1:0]        w_sum;
  logic [3:0]              w_digit;
  int                      w_msd;
  logic                    w_zero;
  logic                    w_div3;
  logic                    w_div5;
  logic                    w_tx_valid;

  // Message builder, evaluated from the latched count; captured in CLASSIFY.
  always_comb begin
    w_sum   = '0;
    w_digit = '0;
    w_msd   = 0;
    w_mlen  = '0;
    w_len   = '0;
    for (int p = 0; p < DEPTH; p++) w_buf[p] = 8'h00;

    for (int k = 0; k < CNT_DIGITS; k++) begin
      w_digit = r_bcd[4*k +: 4];
      w_sum   = w_sum + SUM_W'(w_digit);
      if (w_digit != 4'd0) w_msd = k;
    end
    w_zero = (r_bcd == '0);
    w_div5 = (r_bcd[3:0] == 4'd0) || (r_bcd[3:0] == 4'd5);
    w_div3 = ((w_sum % SUM_W'(3)) == '0);

    if (w_zero) begin
      w_buf[0] = 8'h30;
      w_mlen   = LEN_W'(1);
    end else if (w_div3 && w_div5) begin
      for (int j = 0; j < 8; j++) w_buf[j] = TXT_FIZZBUZZ[8*(7-j) +: 8];
      w_mlen = LEN_W'(8);
    end else if (w_div3) begin
      for (int j = 0; j < 4; j++) w_buf[j] = TXT_FIZZBUZZ[8*(7-j) +: 8];
      w_mlen = LEN_W'(4);
    end else if (w_div5) begin
      for (int j = 0; j < 4; j++) w_buf[j] = TXT_FIZZBUZZ[8*(3-j) +: 8];
      w_mlen = LEN_W'(4);
    end else begin
      // Byte j carries digit (msd - j); leading zeros fall away because the
      // text starts at the most significant non-zero digit.
      for (int j = 0; j < CNT_DIGITS; j++) begin
        for (int k = 0; k < CNT_DIGITS; k++) begin
          if (j + k == w_msd) w_buf[j] = {4'h3, r_bcd[4*k +: 4]};
        end
      end
      w_mlen = LEN_W'(w_msd + 1);
    end

`ifdef FIZZBUZZ_CRLF_EN
    for (int p = 0; p < DEPTH; p++) begin
      if (p == int'(w_mlen))     w_buf[p] = 8'h0D;
      if (p == int'(w_mlen) + 1) w_buf[p] = 8'h0A;
    end
    w_len = w_mlen + LEN_W'(2);
`else
    w_len = w_mlen;
`endif
  end

  // Next-state and byte strobe
  always_comb begin
    w_state_nxt = r_state;
    w_tx_valid  = 1'b0;
    case (r_state)
      S_IDLE:     if (bus.i_go) w_state_nxt = S_CLASSIFY;
      S_CLASSIFY: w_state_nxt = S_EMIT;
      S_EMIT: begin
        if (!bus.i_tx_busy) begin
          w_tx_valid  = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      // Give the transmitter time to raise busy before we trust its low level.
      S_HOLD: begin
        if (bus.i_tx_busy || (r_hold_cnt == HC_W'(HOLD_MAX - 1)))
          w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!bus.i_tx_busy)
          w_state_nxt = (r_idx == r_len) ? S_IDLE : S_EMIT;
      end
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_bcd      <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_hold_cnt <= '0;
      for (int p = 0; p < DEPTH; p++) r_buf[p] <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= (r_state == S_HOLD) ? r_hold_cnt + 1'b1 : '0;
      if ((r_state == S_IDLE) && bus.i_go) r_bcd <= bus.i_bcd;
      if (r_state == S_CLASSIFY) begin
        r_buf <= w_buf;
        r_len <= w_len;
        r_idx <= '0;
      end
      if (w_tx_valid) r_idx <= r_idx + 1'b1;
    end
  end

  assign bus.o_tx_valid = w_tx_valid;
  assign bus.o_tx_data  = w_tx_valid ? r_buf[r_idx[IDX_W-1:0]] : 8'h00;
  assign bus.o_busy     = (r_state != S_IDLE);
  assign bus.o_overrun  = bus.i_go && (r_state != S_IDLE);

endmodule

// File: tb/tb_fizzbuzz_tx_fmt.sv
// tb_fizzbuzz_tx_fmt: randomized and directed bench for fizzbuzz_tx_fmt with a
// behavioural transmitter (configurable busy length) and a reference model
// that classifies the count arithmetically from its integer value.
module tb_fizzbuzz_tx_fmt;
  localparam int CNT_DIGITS = 2;
  localparam int HOLD_MAX   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fizzbuzz_tx_fmt_if #(.CNT_DIGITS(CNT_DIGITS)) bus_if ();

  fizzbuzz_tx_fmt #(
    .CNT_DIGITS(CNT_DIGITS),
    .HOLD_MAX  (HOLD_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.slave)
  );

  int n_chk    = 0;
  int n_err    = 0;
  int cyc      = 0;
  int busy_len = 0;
  int tx_cnt   = 0;
  int ovr_cnt  = 0;
  int go_cyc   = 0;
  logic [7:0] rx_q[$];
  int         rx_cyc_q[$];
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: classify by the integer value of the count.
  function automatic void build_exp(input logic [7:0] bcd);
    int    n;
    string s;
    n = int'(bcd[7:4]) * 10 + int'(bcd[3:0]);
    if (n == 0)            s = "0";
    else if (n % 15 == 0)  s = "FizzBuzz";
    else if (n % 3 == 0)   s = "Fizz";
    else if (n % 5 == 0)   s = "Buzz";
    else                   s = $sformatf("%0d", n);
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
`ifdef FIZZBUZZ_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor plus transmitter model: busy rises the cycle after a byte strobe
  // and stays high for busy_len cycles (never, when busy_len is 0).
  initial begin
    bus_if.i_tx_busy = 1'b0;
    forever begin
      logic v;
      @(negedge clk);
      v = bus_if.o_tx_valid;
      if (rst) begin
        if (v) begin
          rx_q.push_back(bus_if.o_tx_data);
          rx_cyc_q.push_back(cyc);
        end else begin
          check_eq("data_zero_without_valid", bus_if.o_tx_data, 0);
        end
        if (bus_if.o_overrun) ovr_cnt++;
      end
      @(posedge clk);
      #1;
      if (tx_cnt > 0) tx_cnt--;
      if (v && busy_len > 0) tx_cnt = busy_len;
      bus_if.i_tx_busy = (tx_cnt != 0);
    end
  end

  task automatic start_go(input logic [7:0] bcd);
    int t;
    t = 0;
    while (bus_if.o_busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    rx_q.delete();
    rx_cyc_q.delete();
    ovr_cnt = 0;
    @(posedge clk);
    #1;
    bus_if.i_bcd = bcd;
    bus_if.i_go  = 1'b1;
    go_cyc       = cyc;
    @(negedge clk);
    check_eq("no_overrun_on_accept", bus_if.o_overrun, 0);
    @(posedge clk);
    #1;
    bus_if.i_go  = 1'b0;
    bus_if.i_bcd = 8'($urandom);
    @(negedge clk);
    check_eq("busy_rise", bus_if.o_busy, 1);
  endtask

  task automatic finish_check(input logic [7:0] bcd, input int exp_ovr);
    int t;
    int gap;
    int n;
    t = 0;
    while (bus_if.o_busy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check_eq("busy_fall_in_time", (t < 2000), 1);
    gap = (busy_len > 0) ? busy_len + 2 : HOLD_MAX + 2;
    build_exp(bcd);
    check_eq($sformatf("msg_len_%0h", bcd), rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check_eq($sformatf("byte%0d_of_%0h", i, bcd), rx_q[i], exp_q[i]);
    if (rx_cyc_q.size() > 0) begin
      check_eq("first_latency", rx_cyc_q[0] - go_cyc, 2);
      for (int i = 1; i < rx_cyc_q.size(); i++)
        check_eq($sformatf("byte_spacing%0d", i), rx_cyc_q[i] - rx_cyc_q[i-1], gap);
      check_eq("busy_fall_cycle", cyc - rx_cyc_q[rx_cyc_q.size()-1], gap);
    end
    check_eq("overrun_count", ovr_cnt, exp_ovr);
  endtask

  task automatic run_msg(input logic [7:0] bcd, input int blen);
    busy_len = blen;
    start_go(bcd);
    finish_check(bcd, 0);
  endtask

  initial begin
    int t;
    int held;
    logic [7:0] bcd;
    bus_if.i_go  = 1'b0;
    bus_if.i_bcd = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_tx_data", bus_if.o_tx_data, 0);
    check_eq("rst_tx_valid", bus_if.o_tx_valid, 0);
    check_eq("rst_busy", bus_if.o_busy, 0);
    check_eq("rst_overrun", bus_if.o_overrun, 0);

    // Directed messages with slow, medium and silent transmitters
    run_msg(8'h15, 10);
    run_msg(8'h07, 2);
    run_msg(8'h10, 2);
    run_msg(8'h09, 2);
    run_msg(8'h00, 2);
    run_msg(8'h11, 0);

    // Overlapping request is dropped and flagged
    busy_len = 3;
    start_go(8'h12);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus_if.i_bcd = 8'h25;
    bus_if.i_go  = 1'b1;
    @(negedge clk);
    check_eq("overrun_pulse", bus_if.o_overrun, 1);
    @(posedge clk);
    #1;
    bus_if.i_go = 1'b0;
    finish_check(8'h12, 1);
    held = rx_q.size();
    repeat (6) @(negedge clk);
    check_eq("no_second_msg_busy", bus_if.o_busy, 0);
    check_eq("no_second_msg_bytes", rx_q.size(), held);

    // Reset in the middle of a message
    busy_len = 10;
    start_go(8'h15);
    t = 0;
    while (rx_q.size() < 3 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check_eq("third_byte_seen", (t < 500), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("midrst_busy", bus_if.o_busy, 0);
    check_eq("midrst_valid", bus_if.o_tx_valid, 0);
    check_eq("midrst_data", bus_if.o_tx_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    held = rx_q.size();
    repeat (15) @(negedge clk);
    check_eq("no_bytes_after_reset", rx_q.size(), held);
    check_eq("idle_after_reset", bus_if.o_busy, 0);
    run_msg(8'h01, 2);

    // Random counts against the reference model
    repeat (20) begin
      bcd = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      run_msg(bcd, int'($urandom_range(0, 4)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, got %0d checks done, expected completion", n_chk);
    $fatal(1, "watchdog");
  end
endmodule
